trace_event_collector: RTL and testbench

- Synthesizable, parametrised N-core successor to the per-core trace monitor and r3 shadow checker pair.
- Consumes the execution-trace fields of all compute tiles and keeps an r3 shadow per core.
- Decodes l.nop simulation hooks (exit, report, putc) into per-core event FIFOs and arbitrates them round-robin onto one valid/ready event stream.
- Aggregates termination, with a cross-core termination timeout; used in FPGA debug builds and benches.

---
 rtl/trace_event_collector.sv | 223 ++++++++++++++++++++++
 tb/tb_trace_event_collector.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_event_collector.sv
// Multi-core trace event collector: r3 shadows, l.nop hook decode into per-core
// event FIFOs, round-robin arbitration onto one stream, and termination tracking.
module trace_event_collector #(
  parameter  int NUM_CORES    = 16,
  parameter  int FIFO_DEPTH   = 4,
  parameter  int TERM_TIMEOUT = 1024,
  localparam int CORE_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_sys_n,
  input  logic [NUM_CORES-1:0]      trace_valid,
  input  logic [32*NUM_CORES-1:0]   trace_insn,
  input  logic [NUM_CORES-1:0]      trace_wben,
  input  logic [5*NUM_CORES-1:0]    trace_wbreg,
  input  logic [32*NUM_CORES-1:0]   trace_wbdata,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [CORE_W-1:0]         ev_core,
  output logic [1:0]                ev_type,
  output logic [31:0]               ev_data,
  output logic [NUM_CORES-1:0]      core_done,
  output logic                      all_done,
  output logic                      term_timeout,
  output logic [NUM_CORES-1:0]      overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    EV_PUTC   = 2'd0,
    EV_REPORT = 2'd1,
    EV_EXIT   = 2'd2
  } ev_type_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  logic [31:0]          r_r3       [NUM_CORES];
  logic [33:0]          r_mem      [NUM_CORES][FIFO_DEPTH];
  logic [AW-1:0]        r_wptr     [NUM_CORES];
  logic [AW-1:0]        r_rptr     [NUM_CORES];
  logic [CW-1:0]        r_cnt      [NUM_CORES];
  logic [NUM_CORES-1:0] r_done;
  logic [NUM_CORES-1:0] r_overflow;
  logic                 r_all_done;
  logic                 r_term;
  logic [31:0]          r_tcnt;

  arb_state_e           r_arb_state;
  logic [CORE_W-1:0]    r_hold_core;
  logic [CORE_W-1:0]    r_ptr;

  logic [33:0]          w_word     [NUM_CORES];
  logic [NUM_CORES-1:0] w_req;
  logic [NUM_CORES-1:0] w_exit;
  logic [NUM_CORES-1:0] w_full;
  logic [NUM_CORES-1:0] w_push;
  logic [NUM_CORES-1:0] w_pop;
  logic [NUM_CORES-1:0] w_drop;
  logic [NUM_CORES-1:0] w_nonempty;
  logic                 w_found;
  logic [CORE_W-1:0]    w_pick;
  logic [CORE_W-1:0]    w_grant;
  logic [CORE_W-1:0]    w_next_ptr;
  logic [33:0]          w_head;
  logic                 w_fire;

  always_comb begin
    w_nonempty = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_nonempty[i] = (r_cnt[i] != '0);
    end
  end

  // Round-robin search starting at r_ptr, which holds (last granted + 1).
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      idx = 32'(r_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!w_found && w_nonempty[CORE_W'(idx)]) begin
        w_found = 1'b1;
        w_pick  = CORE_W'(idx);
      end
    end
  end

  // A stalled grant is latched so a newly non-empty higher-priority FIFO cannot steal it.
  always_comb begin
    w_grant    = (r_arb_state == ARB_HOLD) ? r_hold_core : w_pick;
    ev_valid   = w_nonempty[w_grant];
    w_head     = r_mem[w_grant][r_rptr[w_grant]];
    ev_core    = ev_valid ? w_grant : '0;
    ev_type    = ev_valid ? w_head[33:32] : 2'd0;
    ev_data    = ev_valid ? w_head[31:0] : 32'd0;
    w_next_ptr = (w_grant == CORE_W'(NUM_CORES - 1)) ? '0 : w_grant + CORE_W'(1);
  end

  assign w_fire = ev_valid && ev_ready;

  // Hooks read the shadow as registered; a same-cycle r3 writeback only reaches the shadow.
  always_comb begin
    w_req  = '0;
    w_exit = '0;
    w_full = '0;
    w_push = '0;
    w_pop  = '0;
    w_drop = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      w_word[i] = '0;
      w_full[i] = (r_cnt[i] == CW'(FIFO_DEPTH));
      w_pop[i]  = w_fire && (w_grant == CORE_W'(i));
      if (trace_valid[i] && !r_done[i] && (trace_insn[32*i+16 +: 16] == 16'h1500)) begin
        case (trace_insn[32*i +: 16])
          16'd1: begin
            w_req[i]  = 1'b1;
            w_exit[i] = 1'b1;
            w_word[i] = {EV_EXIT, r_r3[i]};
          end
          16'd2: begin
            w_req[i]  = 1'b1;
            w_word[i] = {EV_REPORT, r_r3[i]};
          end
          16'd4: begin
            w_req[i]  = 1'b1;
            w_word[i] = {EV_PUTC, 24'd0, r_r3[i][7:0]};
          end
          default: ;
        endcase
      end
      w_push[i] = w_req[i] && (!w_full[i] || w_pop[i]);
      w_drop[i] = w_req[i] && w_full[i] && !w_pop[i];
    end
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        r_r3[i]   <= '0;
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
        for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
          r_mem[i][j] <= '0;
        end
      end
      r_done     <= '0;
      r_overflow <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (trace_valid[i] && trace_wben[i] && (trace_wbreg[5*i +: 5] == 5'd3)) begin
          r_r3[i] <= trace_wbdata[32*i +: 32];
        end
        if (w_push[i]) begin
          r_mem[i][r_wptr[i]] <= w_word[i];
          r_wptr[i]           <= r_wptr[i] + AW'(1);
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + AW'(1);
        end
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
          default: ;
        endcase
        if (w_drop[i]) r_overflow[i] <= 1'b1;
        if (w_exit[i]) r_done[i]     <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_arb_state <= ARB_IDLE;
      r_hold_core <= '0;
      r_ptr       <= '0;
    end else begin
      case (r_arb_state)
        ARB_IDLE: begin
          if (ev_valid && !ev_ready) begin
            r_arb_state <= ARB_HOLD;
            r_hold_core <= w_grant;
          end
          if (w_fire) r_ptr <= w_next_ptr;
        end
        ARB_HOLD: begin
          if (w_fire) begin
            r_arb_state <= ARB_IDLE;
            r_ptr       <= w_next_ptr;
          end
        end
        default: r_arb_state <= ARB_IDLE;
      endcase
    end
  end

  // Timeout counts from the first exit until all_done; term_timeout is sticky.
  always_ff @(posedge clk or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_all_done <= 1'b0;
      r_term     <= 1'b0;
      r_tcnt     <= '0;
    end else begin
      r_all_done <= &r_done;
      if ((TERM_TIMEOUT != 0) && (|r_done) && !r_all_done && !r_term) begin
        r_tcnt <= r_tcnt + 32'd1;
        if (r_tcnt == 32'(TERM_TIMEOUT - 1)) r_term <= 1'b1;
      end
    end
  end

  assign core_done    = r_done;
  assign overflow     = r_overflow;
  assign all_done     = r_all_done;
  assign term_timeout = r_term;

endmodule

// File: tb/tb_trace_event_collector.sv
// Directed self-checking bench for trace_event_collector (16 cores, depth 4, timeout 8).
module tb_trace_event_collector;

  localparam int N = 16;

  logic            clk;
  logic            rst_sys_n;
  logic [N-1:0]    trace_valid;
  logic [32*N-1:0] trace_insn;
  logic [N-1:0]    trace_wben;
  logic [5*N-1:0]  trace_wbreg;
  logic [32*N-1:0] trace_wbdata;
  logic            ev_valid;
  logic            ev_ready;
  logic [3:0]      ev_core;
  logic [1:0]      ev_type;
  logic [31:0]     ev_data;
  logic [N-1:0]    core_done;
  logic            all_done;
  logic            term_timeout;
  logic [N-1:0]    overflow;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  trace_event_collector #(
    .NUM_CORES   (N),
    .FIFO_DEPTH  (4),
    .TERM_TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst_sys_n   (rst_sys_n),
    .trace_valid (trace_valid),
    .trace_insn  (trace_insn),
    .trace_wben  (trace_wben),
    .trace_wbreg (trace_wbreg),
    .trace_wbdata(trace_wbdata),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_core     (ev_core),
    .ev_type     (ev_type),
    .ev_data     (ev_data),
    .core_done   (core_done),
    .all_done    (all_done),
    .term_timeout(term_timeout),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    trace_valid  = '0;
    trace_insn   = '0;
    trace_wben   = '0;
    trace_wbreg  = '0;
    trace_wbdata = '0;
  endtask

  task automatic wb(input int c, input logic [31:0] v);
    trace_valid[c]         = 1'b1;
    trace_wben[c]          = 1'b1;
    trace_wbreg[5*c +: 5]  = 5'd3;
    trace_wbdata[32*c +: 32] = v;
  endtask

  task automatic hook(input int c, input logic [15:0] k);
    trace_valid[c]         = 1'b1;
    trace_insn[32*c +: 32] = {16'h1500, k};
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    clr();
    ev_ready  = 1'b0;
    rst_sys_n = 1'b0;
    #3;
    rst_sys_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    ev_ready  = 1'b0;
    rst_sys_n = 1'b0;
    #12;
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_core", ev_core, 0);
    chk("rst_ev_type", ev_type, 0);
    chk("rst_ev_data", ev_data, 0);
    chk("rst_core_done", core_done, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_term", term_timeout, 0);
    chk("rst_overflow", overflow, 0);
    rst_sys_n = 1'b1;
    step();

    // putc from core 5
    wb(5, 32'h41); step(); clr();
    hook(5, 16'd4); ev_ready = 1'b1; step(); clr();
    chk("putc_valid", ev_valid, 1);
    chk("putc_core", ev_core, 5);
    chk("putc_type", ev_type, 0);
    chk("putc_data", ev_data, 32'h41);
    step();
    chk("putc_popped", ev_valid, 0);

    // round-robin with stall
    do_reset();
    wb(0, 32'h30); wb(3, 32'h33); wb(7, 32'h37); step(); clr();
    hook(0, 16'd4); hook(3, 16'd4); hook(7, 16'd4); step(); clr();
    for (int s = 0; s < 3; s++) begin
      chk("stall_core", ev_core, 0);
      chk("stall_data", ev_data, 32'h30);
      if (s < 2) step();
    end
    ev_ready = 1'b1; step();
    chk("rr1_core", ev_core, 3);
    chk("rr1_data", ev_data, 32'h33);
    step();
    chk("rr2_core", ev_core, 7);
    chk("rr2_data", ev_data, 32'h37);
    step();
    chk("rr_empty", ev_valid, 0);
    hook(3, 16'd4); step(); clr();
    chk("ptr3_core", ev_core, 3);
    step();
    ev_ready = 1'b0;
    hook(0, 16'd4); hook(3, 16'd4); hook(7, 16'd4); step(); clr();
    chk("rr_from3_first", ev_core, 7);
    hook(5, 16'd4); step(); clr();
    chk("hold_vs_new", ev_core, 7);
    ev_ready = 1'b1; step();
    chk("rr_from3_second", ev_core, 0);
    step();
    chk("rr_from3_third", ev_core, 3);
    step();
    chk("rr_late5", ev_core, 5);
    step();
    chk("rr_from3_empty", ev_valid, 0);

    // overflow on core 2
    do_reset();
    wb(2, 32'h61); step(); clr();
    for (int j = 0; j < 6; j++) begin
      hook(2, 16'd4); wb(2, 32'h62 + j); step(); clr();
    end
    chk("ovf_bits", overflow, 16'h0004);
    ev_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("ovf_drain_valid", ev_valid, 1);
      chk("ovf_drain_data", ev_data, 32'h61 + j);
      step();
    end
    chk("ovf_drain_empty", ev_valid, 0);

    // full FIFO with simultaneous pop: no overflow
    do_reset();
    wb(2, 32'd1); step(); clr();
    for (int j = 0; j < 4; j++) begin
      hook(2, 16'd4); wb(2, 32'd2 + j); step(); clr();
    end
    hook(2, 16'd4); ev_ready = 1'b1; step(); clr();
    chk("fullpop_ovf", overflow, 0);
    for (int j = 0; j < 4; j++) begin
      chk("fullpop_data", ev_data, 32'd2 + j);
      step();
    end
    chk("fullpop_empty", ev_valid, 0);

    // r3 same-cycle writeback
    do_reset();
    ev_ready = 1'b1;
    wb(1, 32'h10); step(); clr();
    hook(1, 16'd2); wb(1, 32'h20); step(); clr();
    chk("r3same_type", ev_type, 1);
    chk("r3same_data", ev_data, 32'h10);
    step();
    hook(1, 16'd2); step(); clr();
    chk("r3later_data", ev_data, 32'h20);
    step();

    // all cores exit
    do_reset();
    for (int c = 0; c < N; c++) wb(c, c);
    step(); clr();
    for (int c = 0; c < N; c++) hook(c, 16'd1);
    step(); clr();
    chk("exit_core_done", core_done, 16'hFFFF);
    chk("exit_all_done_early", all_done, 0);
    step();
    chk("exit_all_done", all_done, 1);
    chk("exit_term", term_timeout, 0);
    ev_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      chk("exit_ev_core", ev_core, c);
      chk("exit_ev_type", ev_type, 2);
      chk("exit_ev_data", ev_data, c);
      step();
    end
    chk("exit_drained", ev_valid, 0);
    chk("exit_term_late", term_timeout, 0);

    // timeout with only core 0 exiting
    do_reset();
    hook(0, 16'd1); step(); clr();
    chk("to_core_done", core_done, 16'h0001);
    ev_ready = 1'b1;
    hook(0, 16'd4); step(); clr();
    chk("to_putc_ignored", ev_valid, 0);
    for (int j = 2; j < 8; j++) step();
    chk("to_term_before", term_timeout, 0);
    step();
    chk("to_term_at8", term_timeout, 1);
    step();
    chk("to_term_sticky", term_timeout, 1);
    chk("to_all_done", all_done, 0);

    // async reset mid-drain
    do_reset();
    hook(0, 16'd4); hook(1, 16'd4); hook(3, 16'd1); step(); clr();
    ev_ready = 1'b1; step();
    chk("ar_pre_valid", ev_valid, 1);
    chk("ar_pre_done", core_done, 16'h0008);
    #2;
    rst_sys_n = 1'b0;
    #1;
    chk("ar_valid", ev_valid, 0);
    chk("ar_core", ev_core, 0);
    chk("ar_type", ev_type, 0);
    chk("ar_data", ev_data, 0);
    chk("ar_done", core_done, 0);
    chk("ar_overflow", overflow, 0);
    #2;
    rst_sys_n = 1'b1;
    step(); step();
    chk("ar_no_stale", ev_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
